// File: rtl/demux_pkg.sv
// demux_pkg: shared slot state type, drop counter width and select range helper
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int DROP_CNT_W = 8;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned channels);
        return sel < channels;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-entry output register slot that reads 0 whenever it is empty
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pop;

    assign pop = (state_q == FULL) & pop_ready;

    // A load wins over a pop so a full slot can pass words through at full rate
    always_comb begin
        state_d = load ? FULL : pop ? EMPTY : state_q;
        data_d  = load ? d : pop ? '0 : data_q;
    end

    // Slot register; reset empties the slot and clears its word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid = state_q == FULL;
    assign q     = data_q;

endmodule

// File: rtl/demux_stream_1ton.sv
// demux_stream_1ton: registered 1-to-N valid/ready stream demux; DEMUX_STATS_EN adds drop_cnt
module demux_stream_1ton
    import demux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [WIDTH-1:0]          in_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
`ifdef DEMUX_STATS_EN
    output logic                      sel_err,
    output logic [DROP_CNT_W-1:0]     drop_cnt
`else
    output logic                      sel_err
`endif
);

    logic [CHANNELS-1:0] hit;
    logic                sel_ok;
    logic                drop;
    logic                sel_err_q, sel_err_d;

    // An out-of-range select hits no channel, so it is always ready and discarded
    assign in_ready = ~|(hit & out_valid & ~out_ready);
    assign sel_ok   = sel_in_range(32'(in_sel), 32'(CHANNELS));
    assign drop     = in_valid & ~sel_ok;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign hit[k] = in_sel == SEL_W'(k);
        demux_out_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (in_valid & in_ready & hit[k]),
            .d         (in_data),
            .pop_ready (out_ready[k]),
            .valid     (out_valid[k]),
            .q         (out_data[k*WIDTH +: WIDTH])
        );
    end

    // Sticky error flag next state
    always_comb sel_err_d = sel_err_q | drop;

    // Sticky error register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err_q <= 1'b0;
        else        sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;

`ifdef DEMUX_STATS_EN
    logic [DROP_CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of discarded out-of-range words
    always_comb cnt_d = cnt_q + DROP_CNT_W'(drop && cnt_q != '1);

    // Drop counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign drop_cnt = cnt_q;
`endif

endmodule
